// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// uart_rx_frame : oversampled 8-O-1 UART frame receiver with parity/framing check
// Revision      : 1.0
// ============================================================================
module uart_rx_frame #(
  parameter int clk_freq  = 1_000_000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKCOUNT = clk_freq / baud_rate;
  localparam int CNT_W    = (CLKCOUNT < 4) ? 2 : $clog2(CLKCOUNT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKCOUNT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKCOUNT - 1);

  generate
    if (CLKCOUNT < 4) begin : g_clkcount_check
      $error("uart_rx_frame: clk_freq/baud_rate must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic             armed_q, armed_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q,   par_d;
  logic [7:0]       dout_q,  dout_d;
  logic             valid_q, valid_d;
  logic             perr_q,  perr_d;
  logic             ferr_q,  ferr_d;
  logic             busy_q,  busy_d;

  logic rx_s;
  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    sync1_d = rx;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end
        // A low line is only a start once it has been seen high since the last frame
        if (armed_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          dout_d  = shreg_q;
          perr_d  = ~(^{shreg_q, par_q});
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      armed_q <= 1'b0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_uart_rx_frame : randomized self-checking bench with a frame-level reference model
// Revision         : 1.0
// ============================================================================
module tb_uart_rx_frame;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(
    .clk_freq  (1_000_000),
    .baud_rate (9600)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each transmitted frame yields one expected result record
  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   start_cyc = 0;

  function automatic logic odd_par(input logic [7:0] d);
    return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic p, input logic s, input bit lat);
    exp_t e;
    e.data = d;
    e.perr = ((($countones(d) + int'(p)) % 2) == 0);
    e.ferr = ~s;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input int period);
    rx = b;
    repeat (period) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int period, input int stop_len);
    start_cyc = cyc;
    send_bit(1'b0, period);
    for (int i = 0; i < 8; i++) send_bit(d[i], period);
    send_bit(p, period);
    send_bit(s, stop_len);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Monitor: every strobe must be expected, single-cycle and match the model
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (valid === 1'b1) begin
      check_eq("strobe_width", prev_valid, 1'b0);
      check_eq("valid_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("dout", dout, e.data);
        check_eq("parity_err", parity_err, e.perr);
        check_eq("frame_err", frame_err, e.ferr);
        if (e.lat) begin
          lat = cyc - start_cyc;
          check_eq("latency", (lat >= 1093 && lat <= 1097) ? 32'd1095 : lat, 32'd1095);
        end
      end
    end
    prev_valid = valid;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         per;
    int         gap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_parity_err", parity_err, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(20);

    // Clean 0xA5 at nominal rate, with latency check
    push_exp(8'hA5, 1'b1, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, BIT, BIT);
    drained("a5_drained");
    idle(BIT);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // Randomized loopback with up to +-2% baud mismatch and random idle gaps
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      per = $urandom_range(102, 106);
      gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
      push_exp(d, odd_par(d), 1'b1, 1'b0);
      send_frame(d, odd_par(d), 1'b1, per, per);
      if (gap != 0) idle(gap);
    end
    idle(BIT);
    drained("random_drained");

    // Back-to-back: next start bit immediately after the strobe
    push_exp(8'h6B, odd_par(8'h6B), 1'b1, 1'b0);
    send_frame(8'h6B, odd_par(8'h6B), 1'b1, BIT, BIT / 2 + 3);
    push_exp(8'hC4, odd_par(8'hC4), 1'b1, 1'b0);
    send_frame(8'hC4, odd_par(8'hC4), 1'b1, BIT, BIT);
    idle(BIT);
    drained("b2b_drained");

    // Parity error: 0x00 with parity bit 0
    push_exp(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, BIT, BIT);
    idle(BIT);
    drained("perr_drained");

    // Framing error with line held low, then a clean frame
    push_exp(8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
    send_frame(8'h3C, odd_par(8'h3C), 1'b0, BIT, 3 * BIT);
    drained("ferr_drained");
    idle(2 * BIT);
    push_exp(8'h81, odd_par(8'h81), 1'b1, 1'b0);
    send_frame(8'h81, odd_par(8'h81), 1'b1, BIT, BIT);
    idle(BIT);
    drained("after_ferr_drained");

    // Glitch on idle line
    rx = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_high", busy, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (26) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_low", busy, 1'b0);
    @(posedge clk);
    #1;
    idle(3 * BIT);
    drained("glitch_no_valid");

    // Reset during data bit 4 of 0x5A
    d = 8'h5A;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(d[i], BIT);
    rx = d[4];
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_dout", dout, 8'h00);
    check_eq("midrst_valid", valid, 1'b0);
    check_eq("midrst_parity_err", parity_err, 1'b0);
    check_eq("midrst_frame_err", frame_err, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    idle(2 * BIT);
    drained("midrst_no_valid");
    push_exp(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, BIT, BIT);
    idle(2 * BIT);
    drained("final_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
